regfile_write_arbiter: RTL and testbench

- Owns the register file's single write port and shares it between two writeback requesters.
  - Port A: execute/ALU writeback.
  - Port B: load/memory writeback.
- Arbitrates with round-robin priority and a valid/ready handshake.
- Registers the winning write into the register file's regWrite/writeRegister/writeData inputs.
- Keeps a per-register busy scoreboard so issue logic can stall on pending destinations.

---
 rtl/regfile_write_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Owns the register file's single write port and shares it between two
// writeback requesters: A (execute/ALU) and B (load/memory). Round-robin
// arbitration with a valid/ready handshake; the winning write is registered
// onto the regWrite/writeRegister/writeData lines one cycle later. A
// per-register busy scoreboard lets issue logic stall on pending destinations.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   reserve_valid, reserve_reg     issue logic claims a destination register
//   a_valid/a_reg/a_data/a_ready   requester A handshake
//   b_valid/b_reg/b_data/b_ready   requester B handshake
//   rf_write, rf_write_register,
//   rf_write_data                  registered register-file write port
//   src1_reg/src1_busy,
//   src2_reg/src2_busy             operand hazard lookup
//   busy                           full scoreboard bitmap (bit 0 always 0)
//   err_unreserved                 sticky: write accepted to a non-busy register

module regfile_write_arbiter #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_reg,

    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,

    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,

    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_write_register,
    output logic [DATA_WIDTH-1:0] rf_write_data,

    input  logic [ADDR_WIDTH-1:0] src1_reg,
    input  logic [ADDR_WIDTH-1:0] src2_reg,
    output logic                  src1_busy,
    output logic                  src2_busy,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err_unreserved
);

    // Priority pointer: 0 favours A, 1 favours B on a contended cycle.
    logic                  ptr_q, ptr_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  contended;
    logic                  grant_a, grant_b, xfer;
    logic [ADDR_WIDTH-1:0] xfer_reg;
    logic [DATA_WIDTH-1:0] xfer_data;

    // Grants are gated by reset_n so both readies drop as soon as reset asserts.
    always_comb begin
        contended = a_valid & b_valid;
        grant_a   = reset_n & a_valid & (~b_valid | ~ptr_q);
        grant_b   = reset_n & b_valid & (~a_valid | ptr_q);
        xfer      = grant_a | grant_b;
        xfer_reg  = grant_b ? b_reg  : a_reg;
        xfer_data = grant_b ? b_data : a_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        // Only contended cycles move the pointer: it then names the loser.
        ptr_d = contended ? grant_a : ptr_q;

        wr_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (xfer) begin
            wr_d    = (xfer_reg != '0);
            wreg_d  = xfer_reg;
            wdata_d = xfer_data;
        end

        // Clear first, then set: a new reservation on the same edge wins.
        busy_d = busy_q;
        if (xfer) begin
            busy_d[xfer_reg] = 1'b0;
        end
        if (reserve_valid && (reserve_reg != '0)) begin
            busy_d[reserve_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q | (xfer && (xfer_reg != '0) && !busy_q[xfer_reg]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= 1'b0;
            busy_q  <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_write          = wr_q;
    assign rf_write_register = wreg_q;
    assign rf_write_data     = wdata_q;
    assign busy              = busy_q;
    assign err_unreserved    = err_q;

    // busy_q[0] is held at 0, so register 0 never reads as busy.
    assign src1_busy = busy_q[src1_reg];
    assign src2_busy = busy_q[src2_reg];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. Expected register-file writes
// are queued when a handshake is predicted and popped when the registered
// write port is sampled one cycle later.

module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        reserve_valid;
    logic [4:0]  reserve_reg;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_write;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic [4:0]  src1_reg;
    logic [4:0]  src2_reg;
    logic        src1_busy;
    logic        src2_busy;
    logic [31:0] busy;
    logic        err_unreserved;

    regfile_write_arbiter #(
        .NUM_REGS   (32),
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .reserve_valid     (reserve_valid),
        .reserve_reg       (reserve_reg),
        .a_valid           (a_valid),
        .a_reg             (a_reg),
        .a_data            (a_data),
        .a_ready           (a_ready),
        .b_valid           (b_valid),
        .b_reg             (b_reg),
        .b_data            (b_data),
        .b_ready           (b_ready),
        .rf_write          (rf_write),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .src1_reg          (src1_reg),
        .src2_reg          (src2_reg),
        .src1_busy         (src1_busy),
        .src2_busy         (src2_busy),
        .busy              (busy),
        .err_unreserved    (err_unreserved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference state of the arbiter.
    logic [31:0] busy_m;
    logic        err_m;
    logic        ptr_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_m = '0;
        err_m  = 1'b0;
        ptr_m  = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_idle();
        reserve_valid = 1'b0;
        reserve_reg   = '0;
        a_valid       = 1'b0;
        b_valid       = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven. Checks the
    // combinational outputs, predicts the edge, then checks registered outputs.
    task automatic step();
        logic        ga, gb, x;
        logic [4:0]  xr;
        logic [31:0] xd;
        exp_t        e;
        #1;
        ga = a_valid && (!b_valid || !ptr_m);
        gb = b_valid && (!a_valid || ptr_m);
        check_eq("a_ready", 64'(a_ready), 64'(ga));
        check_eq("b_ready", 64'(b_ready), 64'(gb));
        check_eq("src1_busy", 64'(src1_busy), 64'(busy_m[src1_reg]));
        check_eq("src2_busy", 64'(src2_busy), 64'(busy_m[src2_reg]));
        x  = ga || gb;
        xr = gb ? b_reg : a_reg;
        xd = gb ? b_data : a_data;
        if (x) begin
            e.wr = (xr != 5'd0);
            e.r  = xr;
            e.d  = xd;
            exp_q.push_back(e);
            if (xr != 5'd0 && !busy_m[xr]) err_m = 1'b1;
            busy_m[xr] = 1'b0;
        end
        if (reserve_valid && reserve_reg != 5'd0) busy_m[reserve_reg] = 1'b1;
        busy_m[0] = 1'b0;
        if (a_valid && b_valid) ptr_m = ga;

        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rf_write", 64'(rf_write), 64'(e.wr));
            check_eq("rf_write_register", 64'(rf_write_register), 64'(e.r));
            check_eq("rf_write_data", 64'(rf_write_data), 64'(e.d));
        end else begin
            check_eq("rf_write_idle", 64'(rf_write), 64'd0);
        end
        check_eq("busy", 64'(busy), 64'(busy_m));
        check_eq("err_unreserved", 64'(err_unreserved), 64'(err_m));
        @(negedge clk);
    endtask

    task automatic reserve(input logic [4:0] r);
        set_idle();
        reserve_valid = 1'b1;
        reserve_reg   = r;
        step();
        set_idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n  = 1'b0;
        set_idle();
        a_reg    = '0;
        a_data   = '0;
        b_reg    = '0;
        b_data   = '0;
        src1_reg = '0;
        src2_reg = '0;
        model_reset();

        // 1. Reset state, then ten idle cycles.
        repeat (2) @(negedge clk);
        check_eq("rst_rf_write", 64'(rf_write), 64'd0);
        check_eq("rst_rf_reg", 64'(rf_write_register), 64'd0);
        check_eq("rst_rf_data", 64'(rf_write_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err_unreserved), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // 2. Reserved single write from A.
        src1_reg = 5'd5;
        reserve(5'd5);
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        step();
        set_idle();
        step();

        // 3. Contention: grants must alternate A, B, A, B, A.
        src1_reg = 5'd3;
        src2_reg = 5'd4;
        reserve(5'd3);
        reserve(5'd4);
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
        for (int i = 0; i < 5; i++) step();
        set_idle();
        step();

        do_reset();

        // 4. Write to x0 is accepted but never asserts rf_write.
        reserve(5'd12);
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFFFFFF;
        step();
        set_idle();
        step();

        // 5. Reserve and write x7 on the same edge: reservation wins.
        src1_reg = 5'd7;
        reserve(5'd7);
        reserve_valid = 1'b1; reserve_reg = 5'd7;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h7777;
        step();
        set_idle();
        step();
        check_eq("x7_still_busy", 64'(busy[7]), 64'd1);
        // Unreserved write to x9 raises the sticky error.
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h9999;
        step();
        set_idle();
        step();
        check_eq("err_after_x9", 64'(err_unreserved), 64'd1);

        // 6. Asynchronous reset while a write is visible and A is requesting.
        reserve(5'd2);
        reserve_valid = 1'b1; reserve_reg = 5'd6;
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'hCAFE;
        step();
        set_idle();
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h6666;
        #2;
        check_eq("pre_rst_a_ready", 64'(a_ready), 64'd1);
        check_eq("pre_rst_rf_write", 64'(rf_write), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rf_write", 64'(rf_write), 64'd0);
        check_eq("async_busy", 64'(busy), 64'd0);
        check_eq("async_a_ready", 64'(a_ready), 64'd0);
        check_eq("async_err", 64'(err_unreserved), 64'd0);
        @(posedge clk);
        #1;
        check_eq("hold_rf_write", 64'(rf_write), 64'd0);
        check_eq("hold_busy", 64'(busy), 64'd0);
        check_eq("hold_a_ready", 64'(a_ready), 64'd0);
        @(negedge clk);
        set_idle();
        reset_n = 1'b1;
        model_reset();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
